// File: rtl/shift_add_multiplier.sv
// Sequential WIDTHxWIDTH unsigned shift-and-add multiplier; result and one-cycle mult_ok arrive WIDTH+1 clocks after ld is sampled.
// No backpressure: ld is level-held by the initiator and must fall before a new start; define MULT_EARLY_EXIT_EN to stop once the multiplier runs out of set bits.
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld,
    input  logic [WIDTH-1:0]     mult1,
    input  logic [WIDTH-1:0]     mult2,
    output logic                 mult_ok,
    output logic [2*WIDTH-1:0]   mult_res,
    output logic                 busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        WAIT_LOW
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic                 ok_q, ok_d;

    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mplier_shift;
    logic                 last_step;

    always_comb begin
        acc_sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
        mplier_shift = mplier_q >> 1;
`ifdef MULT_EARLY_EXIT_EN
        // Remaining multiplier bits are all zero, so the accumulator is already final.
        last_step    = (cnt_q == CW'(WIDTH - 1)) || (mplier_shift == '0);
`else
        last_step    = (cnt_q == CW'(WIDTH - 1));
`endif
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        ok_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld) begin
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, mult1};
                    mplier_d = mult2;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift;
                cnt_d    = cnt_q + CW'(1);
                if (last_step) begin
                    res_d   = acc_sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                ok_d    = 1'b1;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                // Level-held ld must drop before another product can start.
                if (!ld) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            ok_q     <= ok_d;
        end
    end

    assign mult_ok  = ok_q;
    assign mult_res = res_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: latency, single-pulse handshake, held-ld, operand isolation and async reset.
module tb_shift_add_multiplier;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           ld;
    logic [W-1:0]   mult1;
    logic [W-1:0]   mult2;
    logic           mult_ok;
    logic [2*W-1:0] mult_res;
    logic           busy;

    int             total = 0;
    int             bad   = 0;
    logic [2*W-1:0] exp_q[$];

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .ld       (ld),
        .mult1    (mult1),
        .mult2    (mult2),
        .mult_ok  (mult_ok),
        .mult_res (mult_res),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat_of(input logic [W-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
        int k = 0;
        for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
        return 1 + ((k < 1) ? 1 : k);
`else
        return W + 1;
`endif
    endfunction

    // Raise ld with operands, wait for mult_ok, check latency, busy and result.
    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int chg_at);
        int             cyc;
        bit             seen;
        logic [2*W-1:0] p;
        logic [2*W-1:0] e;
        p = a * b;
        exp_q.push_back(p);
        mult1 = a;
        mult2 = b;
        ld    = 1'b1;
        cyc   = 0;
        seen  = 1'b0;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (cyc == chg_at) begin
                mult1 = 8'h01;
                mult2 = 8'h01;
            end
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (mult_ok) seen = 1'b1;
        end
        chk({tag, "_lat"}, cyc - 1, lat_of(b));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_res"}, {16'd0, mult_res}, {16'd0, e});
        end else begin
            chk({tag, "_sb_empty"}, exp_q.size(), 1);
        end
    endtask

    // Initiator behaviour after a pulse: drop ld one cycle later, wait for idle.
    task automatic finish_hs(input string tag);
        int n;
        tick();
        chk({tag, "_pulse1"}, {31'd0, mult_ok}, 32'd0);
        ld = 1'b0;
        n  = 0;
        while (busy && n < 5) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int pulses;
        reset = 1'b0;
        ld    = 1'b0;
        mult1 = '0;
        mult2 = '0;
        tick();
        tick();
        chk("rst_ok",   {31'd0, mult_ok}, 32'd0);
        chk("rst_res",  {16'd0, mult_res}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        tick();

        // Maximum operands
        run("ffxff", 8'hFF, 8'hFF, 0);
        finish_hs("ffxff");

        // ld held high never retriggers
        run("hold", 8'h80, 8'h02, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mult_ok) pulses++;
        end
        chk("hold_nopulse", pulses, 0);
        chk("hold_res", {16'd0, mult_res}, 32'h0100);
        ld = 1'b0;
        tick();
        tick();
        run("hold2", 8'h80, 8'h02, 0);
        finish_hs("hold2");

        // Color-wheel style back-to-back sequence
        run("cw0", 8'h80, 8'h10, 0);
        finish_hs("cw0");
        run("cw1", 8'h80, 8'hFF, 0);
        finish_hs("cw1");
        run("cw2", 8'h80, 8'h00, 0);
        finish_hs("cw2");
        run("cw3", 8'h80, 8'h7F, 0);
        finish_hs("cw3");

        // Operand changes after capture are ignored
        run("chg", 8'h55, 8'hAA, 3);
        finish_hs("chg");

        // Async reset mid-RUN
        mult1 = 8'h55;
        mult2 = 8'hAA;
        ld    = 1'b1;
        tick();
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_ok",   {31'd0, mult_ok}, 32'd0);
        chk("midrst_res",  {16'd0, mult_res}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        ld = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        run("post_rst", 8'h03, 8'h05, 0);
        finish_hs("post_rst");

        // Latency depends on multiplier only when early exit is built in
        run("ee03", 8'h10, 8'h03, 0);
        finish_hs("ee03");
        run("ee00", 8'h10, 8'h00, 0);
        finish_hs("ee00");

        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential 8x8 shift-and-add multiplier.
- Responder end of the mult1/mult2/ld/mult_ok/mult_res handshake driven by the color wheel processor for its intensity scaling.
- Latches operands on a load request, iterates one multiplier bit per clock, then returns a full-width product with a single-cycle done pulse.
- Sits beside the color wheel processor in the RGBW controller top level.

Parameters:
WIDTH, 8, operand width; product width is 2*WIDTH

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset
- ld  input  1  load/start request from initiator, level
- mult1  input  WIDTH  multiplicand
- mult2  input  WIDTH  multiplier
- mult_ok  output  1  result-valid pulse, registered
- mult_res  output  2*WIDTH  unsigned product, registered, held until next result
- busy  output  1  high from operand capture until the handshake completes (RUN, DONE, WAIT_LOW)

Interface decision: one clock; reset is asynchronous and active-low (ports clk, reset).

Behaviour:
Reset:
- Asynchronous on reset=0: state=IDLE; mult_ok=0, mult_res=0, busy=0; internal accumulator, shift registers and counter cleared.
- Takes effect immediately, including mid-computation.
- No partial result is ever presented.

States:
- IDLE
  - mult_ok=0.
  - ld=1 sampled at edge N: latch acc=0, mcand={WIDTH zeros, mult1}, mplier=mult2, cnt=0; go to RUN.
- RUN (one step per clock)
  - If mplier[0]=1: acc <= acc + mcand (2*WIDTH wide, no overflow possible).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - When cnt reaches WIDTH-1 on this step: mult_res <= final acc; go to DONE.
- DONE
  - mult_ok=1 for exactly one clock; go to WAIT_LOW unconditionally.
- WAIT_LOW
  - mult_ok=0; stay while ld=1; go to IDLE when ld=0.

Timing and handshake rules:
- Latency: mult_ok high in the cycle after edge N+WIDTH+1, i.e. WIDTH+1 clocks after the ld-sampling edge. mult_res is valid in the same cycle.
- mult_ok must be a single-cycle pulse. The initiator drops ld one cycle after seeing mult_ok=1 and advances on any mult_ok=1, so a held mult_ok would double-advance it.
- A new start requires ld to return to 0 after DONE. ld held high continuously never retriggers.
- mult1/mult2 changes after the capture edge are ignored.
- ld falling during RUN is ignored: the computation completes, the pulse is still emitted, and WAIT_LOW exits on the next clock.
- mult_res is unchanged from DONE until the next DONE, so the initiator may sample it any time mult_ok=1.
- Back-to-back operation with the color wheel timing yields 4 clocks of overhead per product beyond RUN.
- Arithmetic is unsigned; 0xFF*0xFF=0xFE01 fits 16 bits.

Optional Feature:
MULT_EARLY_EXIT_EN
- Defined: RUN also exits to DONE after any step where the shifted mplier becomes 0. Latency = 1 + max(1, k) clocks to mult_ok, where k = index of the highest set bit of mult2, plus 1. For mult2=0, latency is 2. Result is identical.
- Undefined: fixed WIDTH-step latency regardless of operands.

Test Plan:
1. reset=1; ld rises with mult1=0xFF, mult2=0xFF -> mult_ok=1 for exactly 1 clock, 9 clocks after the ld edge; mult_res=0xFE01; busy high throughout.
2. mult1=0x80, mult2=0x02, ld held high 20 clocks -> one mult_ok pulse, mult_res=0x0100; no second pulse until ld=0 then 1, which gives a second pulse.
3. Emulate the color wheel: 4 sequential products (lint=0x80 with 0x10, 0xFF, 0x00, 0x7F), dropping ld the cycle after mult_ok -> results 0x0800, 0x7F80, 0x0000, 0x3F80, each captured once, never stale.
4. Start 0x55*0xAA, change mult1/mult2 to 0x01 mid-RUN -> mult_res=0x3872.
5. Assert reset=0 at cycle 4 of RUN -> mult_ok=0, mult_res=0, busy=0 immediately; after release a fresh ld with 3*5 gives 0x000F.
6. With MULT_EARLY_EXIT_EN: 0x10*0x03 -> mult_res=0x0030 with mult_ok 3 clocks after the ld edge; mult2=0x00 -> 0x0000 after 2 clocks. Without the macro, both take 9 clocks.
